// File: rtl/decode_issue_unit_pkg.sv
// Shared types for the decode/issue slice.
// Contents:
//   opcode_t    - RV32 base opcodes recognised by the decoder
//   state_t     - decode/issue FSM states
//   imm_fmt_t   - immediate encoding formats
//   dec_t       - decoded view of one instruction word
//   form_imm    - builds the 32-bit sign-extended immediate for a format
//   decode_inst - full field/usage decode of one instruction word
package decode_issue_unit_pkg;

    typedef enum logic [6:0] {
        OPCODE_LOAD   = 7'h03,
        OPCODE_OP_IMM = 7'h13,
        OPCODE_AUIPC  = 7'h17,
        OPCODE_STORE  = 7'h23,
        OPCODE_OP     = 7'h33,
        OPCODE_LUI    = 7'h37,
        OPCODE_BRANCH = 7'h63,
        OPCODE_JALR   = 7'h67,
        OPCODE_JAL    = 7'h6F
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        HAZARD,
        READ,
        OUT,
        DRAIN
    } state_t;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic [31:0] imm;
    } dec_t;

    function automatic logic signed [31:0] form_imm(input logic [31:0] inst, input imm_fmt_t fmt);
        logic signed [31:0] imm;
        case (fmt)
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = {{20{inst[31]}}, inst[31:20]};
        endcase
        return imm;
    endfunction

    function automatic dec_t decode_inst(input logic [31:0] inst);
        dec_t     d;
        opcode_t  op;
        imm_fmt_t fmt;
        d        = '0;
        op       = opcode_t'(inst[6:0]);
        fmt      = FMT_I;
        d.opcode = inst[6:0];
        d.rd     = inst[11:7];
        d.funct3 = inst[14:12];
        d.rs1    = inst[19:15];
        d.rs2    = inst[24:20];
        d.funct7 = inst[31:25];
        case (op)
            OPCODE_OP: begin
                d.uses_rs1  = 1'b1;
                d.uses_rs2  = 1'b1;
                d.writes_rd = 1'b1;
            end
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR: begin
                d.uses_rs1  = 1'b1;
                d.writes_rd = 1'b1;
            end
            OPCODE_STORE: begin
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
                fmt        = FMT_S;
            end
            OPCODE_BRANCH: begin
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
                fmt        = FMT_B;
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
                d.writes_rd = 1'b1;
                fmt         = FMT_U;
            end
            OPCODE_JAL: begin
                d.writes_rd = 1'b1;
                fmt         = FMT_J;
            end
            default: ;
        endcase
        // x0 is hardwired, so a write to it never creates a dependency
        d.writes_rd = d.writes_rd && (d.rd != 5'd0);
        d.imm       = form_imm(inst, fmt);
        return d;
    endfunction

endpackage

// File: rtl/decode_issue_unit_if.sv
// Bus bundle between fetch, register file, writeback, execute and the
// decode/issue unit.
//   fetch : in_valid, in_ready, in_inst, in_pc, flush
//   rf    : rf_req_en/rf_req_addr (per port), rf_rsp_done/rf_rsp_data (per port)
//   wb    : wb_valid, wb_rd
//   issue : out_valid, out_ready, out_pc, out_opcode, out_funct3, out_funct7,
//           out_rs1, out_rs2, out_rd, out_imm, out_rs1_data, out_rs2_data
//   stat  : stall_cnt
// slave is the decode unit's view, master the surrounding pipeline's view.
interface decode_issue_unit_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 16
);
    localparam int AW = $clog2(NREG);

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_inst;
    logic [XLEN-1:0]      in_pc;
    logic                 flush;

    logic [1:0]           rf_req_en;
    logic [1:0][AW-1:0]   rf_req_addr;
    logic [1:0]           rf_rsp_done;
    logic [1:0][XLEN-1:0] rf_rsp_data;

    logic                 wb_valid;
    logic [AW-1:0]        wb_rd;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [6:0]           out_opcode;
    logic [2:0]           out_funct3;
    logic [6:0]           out_funct7;
    logic [AW-1:0]        out_rs1;
    logic [AW-1:0]        out_rs2;
    logic [AW-1:0]        out_rd;
    logic [XLEN-1:0]      out_imm;
    logic [XLEN-1:0]      out_rs1_data;
    logic [XLEN-1:0]      out_rs2_data;
    logic [CNT_W-1:0]     stall_cnt;

    modport slave (
        input  in_valid, in_inst, in_pc, flush,
        output in_ready,
        output rf_req_en, rf_req_addr,
        input  rf_rsp_done, rf_rsp_data,
        input  wb_valid, wb_rd,
        input  out_ready,
        output out_valid, out_pc, out_opcode, out_funct3, out_funct7,
        output out_rs1, out_rs2, out_rd, out_imm, out_rs1_data, out_rs2_data,
        output stall_cnt
    );

    modport master (
        output in_valid, in_inst, in_pc, flush,
        input  in_ready,
        input  rf_req_en, rf_req_addr,
        output rf_rsp_done, rf_rsp_data,
        output wb_valid, wb_rd,
        output out_ready,
        input  out_valid, out_pc, out_opcode, out_funct3, out_funct7,
        input  out_rs1, out_rs2, out_rd, out_imm, out_rs1_data, out_rs2_data,
        input  stall_cnt
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Register busy-bit scoreboard.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   set_en, set_addr    - mark a register as having a pending write (issue)
//   clr_en, clr_addr    - retire a pending write (writeback)
//   q1_addr, q2_addr    - source registers to query
//   q1_busy, q2_busy    - query results, with same-cycle writeback bypass
module decode_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] q1_addr,
    input  logic [AW-1:0] q2_addr,
    output logic          q1_busy,
    output logic          q2_busy
);
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREG; i++) begin
            if (clr_en && clr_addr == AW'(i)) busy_d[i] = 1'b0;
            if (set_en && set_addr == AW'(i)) busy_d[i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // A register being retired this cycle is already safe to read.
    always_comb begin
        q1_busy = 1'b0;
        q2_busy = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (q1_addr == AW'(i)) q1_busy = busy_q[i];
            if (q2_addr == AW'(i)) q2_busy = busy_q[i];
        end
        if (clr_en && clr_addr == q1_addr) q1_busy = 1'b0;
        if (clr_en && clr_addr == q2_addr) q2_busy = 1'b0;
    end
endmodule

// File: rtl/decode_issue_unit.sv
// Single-entry decode and issue stage.
// Accepts one instruction from fetch, waits out register hazards against the
// scoreboard, reads its source operands from a variable-latency register
// file and presents the decoded instruction to execute.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - decode_issue_unit_if.slave: fetch, regfile, writeback, issue, stall_cnt
module decode_issue_unit
    import decode_issue_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    decode_issue_unit_if.slave bus
);
    localparam int AW = $clog2(NREG);

    state_t               state_q;
    state_t               state_d;
    logic [31:0]          buf_inst;
    logic [XLEN-1:0]      buf_pc;
    dec_t                 dec;
    logic [AW-1:0]        rs1;
    logic [AW-1:0]        rs2;
    logic [AW-1:0]        rd;
    logic signed [31:0]   imm32;
    logic signed [XLEN-1:0] imm_ext;
    logic [1:0]           need;
    logic [1:0]           done_q;
    logic [1:0][XLEN-1:0] data_q;
    logic [1:0]           done_now;
    logic                 all_done;
    logic                 busy_rs1;
    logic                 busy_rs2;
    logic                 hazard;
    logic                 accept;
    logic                 issue;
    logic                 req_fire;
    logic                 load_out;
    logic                 sb_set;
    logic [XLEN-1:0]      rs1_val;
    logic [XLEN-1:0]      rs2_val;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign dec     = decode_inst(buf_inst);
    assign rs1     = AW'(dec.rs1);
    assign rs2     = AW'(dec.rs2);
    assign rd      = AW'(dec.rd);
    assign imm32   = dec.imm;
    assign imm_ext = XLEN'(imm32);
    assign need    = {dec.uses_rs2, dec.uses_rs1};

    // A port is finished if it was never requested, already answered, or answers now.
    assign done_now = done_q | bus.rf_rsp_done | ~need;
    assign all_done = &done_now;

    assign hazard   = (dec.uses_rs1 && busy_rs1) || (dec.uses_rs2 && busy_rs2);
    assign accept   = bus.in_valid && bus.in_ready;
    assign issue    = (state_q == OUT) && bus.out_ready && !bus.flush;
    assign req_fire = (state_q == HAZARD) && !hazard && !bus.flush;
    assign load_out = (state_q == READ) && all_done && !bus.flush;
    assign sb_set   = issue && dec.writes_rd;

    assign rs1_val = !need[0] ? '0 : (done_q[0] ? data_q[0] : bus.rf_rsp_data[0]);
    assign rs2_val = !need[1] ? '0 : (done_q[1] ? data_q[1] : bus.rf_rsp_data[1]);

    decode_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set),
        .set_addr (rd),
        .clr_en   (bus.wb_valid),
        .clr_addr (bus.wb_rd),
        .q1_addr  (rs1),
        .q2_addr  (rs2),
        .q1_busy  (busy_rs1),
        .q2_busy  (busy_rs2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = HAZARD;
            end
            HAZARD: begin
                if (bus.flush)   state_d = IDLE;
                else if (!hazard) state_d = READ;
            end
            READ: begin
                if (all_done)       state_d = bus.flush ? IDLE : OUT;
                else if (bus.flush) state_d = DRAIN;
            end
            OUT: begin
                if (bus.flush)          state_d = IDLE;
                else if (bus.out_ready) state_d = accept ? HAZARD : IDLE;
            end
            DRAIN: begin
                if (all_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready       = !bus.flush &&
                             ((state_q == IDLE) || ((state_q == OUT) && bus.out_ready));
        bus.out_valid      = (state_q == OUT);
        bus.rf_req_en      = req_fire ? need : 2'b00;
        bus.rf_req_addr[0] = bus.rf_req_en[0] ? rs1 : '0;
        bus.rf_req_addr[1] = bus.rf_req_en[1] ? rs2 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_inst <= '0;
            buf_pc   <= '0;
        end else if (accept) begin
            buf_inst <= bus.in_inst;
            buf_pc   <= bus.in_pc;
        end
    end

    // Per-port response capture; responses outside READ/DRAIN are stale and dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= '0;
            data_q <= '0;
        end else if (req_fire) begin
            done_q <= '0;
        end else if ((state_q == READ) || (state_q == DRAIN)) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.rf_rsp_done[i]) begin
                    done_q[i] <= 1'b1;
                    data_q[i] <= bus.rf_rsp_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_pc       <= '0;
            bus.out_opcode   <= '0;
            bus.out_funct3   <= '0;
            bus.out_funct7   <= '0;
            bus.out_rs1      <= '0;
            bus.out_rs2      <= '0;
            bus.out_rd       <= '0;
            bus.out_imm      <= '0;
            bus.out_rs1_data <= '0;
            bus.out_rs2_data <= '0;
        end else if (load_out) begin
            bus.out_pc       <= buf_pc;
            bus.out_opcode   <= dec.opcode;
            bus.out_funct3   <= dec.funct3;
            bus.out_funct7   <= dec.funct7;
            bus.out_rs1      <= rs1;
            bus.out_rs2      <= rs2;
            bus.out_rd       <= rd;
            bus.out_imm      <= imm_ext;
            bus.out_rs1_data <= rs1_val;
            bus.out_rs2_data <= rs2_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          bus.stall_cnt <= '0;
        else if ((state_q == HAZARD) && hazard && !bus.flush) bus.stall_cnt <= sat_inc(bus.stall_cnt);
    end
endmodule
